fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the program counter, resolves relative
// branches, holds the current instruction while a STIN/LOUT handshake is
// pending, and stops permanently on a branch-to-self.
module fetch_sequencer #(
  parameter int PC_W  = 6,
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             pc_rel_branch,
  input  logic             reg_write,
  input  logic             read_in,
  input  logic             write_out,
  input  logic [OFF_W-1:0] offset,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  pc,
  output logic             in_ready,
  output logic             out_valid,
  output logic             reg_we,
  output logic             stall,
  output logic             halted,
  output logic [7:0]       stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      stall_cnt_q, stall_cnt_d;

  logic            active;
  logic            in_window;
  logic            out_window;
  logic            wr_op;
  logic            in_stall;
  logic            out_stall;
  logic            halt_hit;
  logic [PC_W-1:0] pc_next;

  // Sign-extend (or truncate) the branch offset to the PC width; the sum
  // then wraps naturally modulo 2^PC_W.
  function automatic logic [PC_W-1:0] ext_offset(input logic [OFF_W-1:0] off);
    logic signed [OFF_W-1:0] off_s;
    logic signed [PC_W-1:0]  off_e;
    off_s = signed'(off);
    off_e = PC_W'(off_s);
    return unsigned'(off_e);
  endfunction

  // Saturating 8-bit increment for the stall counter (sticks at 255).
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Handshake windows, stall detection and gated write enable.
  always_comb begin
    active     = (state_q != HALT);
    in_window  = (state_q == RUN) || (state_q == WAIT_IN);
    out_window = (state_q == RUN) || (state_q == WAIT_OUT);
    // An instruction flagged as both STIN and LOUT is handled as STIN.
    wr_op      = write_out && !read_in;
    in_ready   = in_window && read_in;
    out_valid  = out_window && wr_op;
    in_stall   = in_ready && !in_valid;
    out_stall  = out_valid && !out_ready;
    stall      = in_stall || out_stall;
    reg_we     = reg_write && !stall && active;
    halted     = (state_q == HALT);
  end

  // Branch target / fall-through address and branch-to-self detection.
  always_comb begin
    pc_next  = pc_q + (pc_rel_branch ? ext_offset(offset) : PC_W'(1));
    halt_hit = pc_rel_branch && (pc_next == pc_q);
  end

  // Next-state, next-pc and stall-counter update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stall_cnt_d = stall ? sat_inc8(stall_cnt_q) : stall_cnt_q;
    case (state_q)
      RUN, WAIT_IN, WAIT_OUT: begin
        if (in_stall) begin
          state_d = WAIT_IN;
        end else if (out_stall) begin
          state_d = WAIT_OUT;
        end else if (halt_hit) begin
          // Branch-to-self: stop here with pc frozen on the halting branch.
          state_d = HALT;
        end else begin
          state_d = RUN;
          pc_d    = pc_next;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, program counter and stall counter registers; reset abandons any
  // pending transfer by returning straight to RUN at address 0.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= RUN;
      pc_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each step drives one instruction on a
// falling edge, checks the combinational handshake outputs, queues the pc
// expected after the next rising edge and compares it once that edge passes.
module tb_fetch_sequencer;

  localparam int PC_W  = 6;
  localparam int OFF_W = 8;

  logic             clk;
  logic             nReset;
  logic             pc_rel_branch;
  logic             reg_write;
  logic             read_in;
  logic             write_out;
  logic [OFF_W-1:0] offset;
  logic             in_valid;
  logic             out_ready;
  logic [PC_W-1:0]  pc;
  logic             in_ready;
  logic             out_valid;
  logic             reg_we;
  logic             stall;
  logic             halted;
  logic [7:0]       stall_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [PC_W-1:0] exp_q[$];

  fetch_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
    .clk          (clk),
    .nReset       (nReset),
    .pc_rel_branch(pc_rel_branch),
    .reg_write    (reg_write),
    .read_in      (read_in),
    .write_out    (write_out),
    .offset       (offset),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .pc           (pc),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .reg_we       (reg_we),
    .stall        (stall),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic br, input logic rw, input logic ri, input logic wo,
                       input logic [7:0] off, input logic iv, input logic ordy);
    pc_rel_branch = br;
    reg_write     = rw;
    read_in       = ri;
    write_out     = wo;
    offset        = off;
    in_valid      = iv;
    out_ready     = ordy;
  endtask

  // One instruction cycle, entered and left on a falling edge.
  task automatic cyc(input string tag,
                     input logic br, input logic rw, input logic ri, input logic wo,
                     input logic [7:0] off, input logic iv, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic e_we, input logic e_st,
                     input logic [PC_W-1:0] e_pc);
    logic [PC_W-1:0] want;
    drive(br, rw, ri, wo, off, iv, ordy);
    #1;
    chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".reg_we"},    32'(reg_we),    32'(e_we));
    chk({tag, ".stall"},     32'(stall),     32'(e_st));
    exp_q.push_back(e_pc);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    chk({tag, ".pc"}, 32'(pc), 32'(want));
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    nReset = 1'b0;
    #2;
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    nReset = 1'b1;

    // Straight-line NOPs.
    for (int i = 1; i <= 5; i++)
      cyc("nop", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, PC_W'(i));
    chk("nop.stall_cnt", 32'(stall_cnt), 32'd0);

    // Branch arithmetic and wrap-around.
    cyc("br57", 1, 0, 0, 0, 8'd57, 0, 0, 0, 0, 0, 0, 6'd62);
    cyc("br+3wrap", 1, 0, 0, 0, 8'd3, 0, 0, 0, 0, 0, 0, 6'd1);
    cyc("br-2", 1, 0, 0, 0, 8'hFE, 0, 0, 0, 0, 0, 0, 6'd63);
    cyc("incwrap", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 6'd0);
    cyc("regw", 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 6'd1);

    // STIN waits three cycles for data, retires on the fourth.
    for (int i = 0; i < 3; i++)
      cyc("stin_wait", 0, 1, 1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 6'd1);
    cyc("stin_go", 0, 1, 1, 0, 8'h00, 1, 0, 1, 0, 1, 0, 6'd2);
    chk("stin.stall_cnt", 32'(stall_cnt), 32'd3);

    // LOUT waits two cycles for the sink; count is cumulative since reset.
    for (int i = 0; i < 2; i++)
      cyc("lout_wait", 0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 6'd2);
    cyc("lout_go", 0, 0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 6'd3);
    chk("lout.stall_cnt", 32'(stall_cnt), 32'd5);

    // Both STIN and LOUT flagged: only the input side applies.
    cyc("both", 0, 0, 1, 1, 8'h00, 1, 0, 1, 0, 0, 0, 6'd4);

    // Reach pc=10 then branch to self.
    cyc("br+6", 1, 0, 0, 0, 8'd6, 0, 0, 0, 0, 0, 0, 6'd10);
    cyc("halt", 1, 1, 0, 0, 8'd0, 0, 0, 0, 0, 1, 0, 6'd10);
    chk("halt.halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      logic [6:0] r;
      r = 7'($urandom);
      cyc("halted_in", r[0], r[1], r[2], r[3], 8'($urandom), r[4], r[5],
          0, 0, 0, 0, 6'd10);
    end
    chk("halt.halted_end", 32'(halted), 32'd1);
    chk("halt.stall_cnt", 32'(stall_cnt), 32'd5);

    // Asynchronous reset out of HALT.
    #1 nReset = 1'b0;
    #1;
    chk("rst2.pc", 32'(pc), 32'd0);
    chk("rst2.halted", 32'(halted), 32'd0);
    chk("rst2.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    nReset = 1'b1;

    // Park in WAIT_IN at pc=7, then reset between edges.
    cyc("br+7", 1, 0, 0, 0, 8'd7, 0, 0, 0, 0, 0, 0, 6'd7);
    cyc("win7", 0, 1, 1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 6'd7);
    chk("win7.stall_cnt", 32'(stall_cnt), 32'd1);
    #1 nReset = 1'b0;
    #1;
    chk("rst3.pc", 32'(pc), 32'd0);
    chk("rst3.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst3.halted", 32'(halted), 32'd0);
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk("rst3.pc_held", 32'(pc), 32'd0);
    @(negedge clk);
    nReset = 1'b1;

    // LOUT presents immediately, so the pending STIN was abandoned.
    cyc("post_rst_lout", 0, 1, 0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 6'd0);
    cyc("post_rst_go", 0, 0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 6'd1);
    chk("post_rst.stall_cnt", 32'(stall_cnt), 32'd1);

    // Long stall drives the counter into saturation.
    for (int i = 0; i < 300; i++)
      cyc("long_stall", 0, 1, 1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 6'd1);
    chk("sat.stall_cnt", 32'(stall_cnt), 32'd255);
    cyc("long_go", 0, 1, 1, 0, 8'h00, 1, 0, 1, 0, 1, 0, 6'd2);
    chk("sat.stall_cnt_hold", 32'(stall_cnt), 32'd255);

    // Offset 0x40 truncates to 0 at 6 bits: also a branch to self.
    cyc("halt_trunc", 1, 0, 0, 0, 8'h40, 0, 0, 0, 0, 0, 0, 6'd2);
    chk("halt_trunc.halted", 32'(halted), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
